operand_stream_tx: RTL and testbench
====================================

OPERAND_STREAM_TX -- requirements
Module: operand_stream_tx

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32: width of one stream block in bits.
REQ-002 SHALL have parameter BITS_IN_NUM, default 4096: operand width; BLOCKS = BITS_IN_NUM/REGISTER_SIZE (128).
REQ-003 SHALL have port clk_in, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port load_valid_in, input, 1: write one operand block this cycle.
REQ-006 SHALL have port load_sel_in, input, 1: 0 = operand n, 1 = operand m.
REQ-007 SHALL have port load_addr_in, input, $clog2(BLOCKS): block index, 0 = least significant.
REQ-008 SHALL have port load_data_in, input, REGISTER_SIZE: block value.
REQ-009 SHALL have port start_in, input, 1: request one transmission of both operands.
REQ-010 SHALL have port consumer_ready_in, input, 1: downstream multiplier idle and able to accept a stream.
REQ-011 SHALL have port consumer_final_in, input, 1: downstream one-cycle pulse marking end of its result stream.
REQ-012 SHALL have port n_out, output, REGISTER_SIZE: current n block.
REQ-013 SHALL have port m_out, output, REGISTER_SIZE: current m block.
REQ-014 SHALL have port valid_out, output, 1: n_out/m_out carry a valid block pair.
REQ-015 SHALL have port busy_out, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done_out, output, 1: one-cycle pulse when the transaction completes.

Function
REQ-017 SHALL implement states IDLE, ARMED, STREAMING, DRAINING, WAITING.
REQ-018 SHALL, in IDLE only, write load_data_in to storage location load_sel_in*BLOCKS + load_addr_in when load_valid_in=1; loads in any other state are ignored and do not modify storage.
REQ-019 SHALL, in IDLE with start_in=1, go to STREAMING if consumer_ready_in=1, else go to ARMED; start_in outside IDLE is ignored.
REQ-020 SHALL, in ARMED, hold until consumer_ready_in=1, then go to STREAMING.
REQ-021 SHALL, in STREAMING, issue read addresses 0..BLOCKS-1 on consecutive cycles (n at k, m at BLOCKS+k), then go to DRAINING.
REQ-022 SHALL account for 2-cycle storage read latency: valid_out high for exactly BLOCKS contiguous cycles, pair k appearing 2 cycles after address k issues; with start_in and consumer_ready_in both high at cycle T, valid_out is high for cycles T+3..T+130 inclusive.
REQ-023 SHALL never deassert valid_out inside a stream; consumer_ready_in changes after STREAMING entry are ignored.
REQ-024 SHALL drive n_out=0 and m_out=0 whenever valid_out=0.
REQ-025 SHALL, in DRAINING, wait until the last pair has been presented, then go to WAITING.
REQ-026 SHALL, in WAITING, on consumer_final_in=1 pulse done_out for one cycle and return to IDLE on the same edge.
REQ-027 SHALL ignore consumer_final_in in every state except WAITING.
REQ-028 SHALL retain stored operands across transactions; a second start_in replays identical data.
REQ-029 SHALL, if load_valid_in and start_in are both high in IDLE, perform the write and also accept the start; the written block is included in the stream.

Reset
REQ-030 SHALL, while rst_in=1, force state IDLE, valid_out=0, done_out=0, busy_out=0, n_out=0, m_out=0, read address 0.
REQ-031 SHALL, on reset mid-stream, drop valid_out on the cycle after rst_in is sampled and emit no further pairs; storage contents are not cleared.

Structure
REQ-032 SHALL take REGISTER_SIZE, BITS_IN_NUM, BLOCKS and the state enum from shared package bignum_pkg, also used by the multiplier.
REQ-033 SHALL store both operands in one instance of xilinx_true_dual_port_read_first_2_clock_ram, depth 2*BLOCKS: port A writes loads and reads n, port B reads m.

Verification
REQ-034 SHALL cover: load n[k]=k+1, m[k]=0x8000_0000+k for all k, start with ready high at T -> valid_out high T+3..T+130, pair k = (k+1, 0x8000_0000+k).
REQ-035 SHALL cover: start with consumer_ready_in low 10 cycles -> stays ARMED, valid_out low; ready rises at R -> first pair at R+3.
REQ-036 SHALL cover: consumer_final_in pulsed during STREAMING and 5 cycles into WAITING -> first ignored, second yields done_out pulse, busy_out low next cycle.
REQ-037 SHALL cover: load n[5]=0xDEAD_BEEF during STREAMING -> ignored; replayed n[5]=6.
REQ-038 SHALL cover: rst_in at pair 40 -> valid_out low next cycle; restart without reload -> identical 128 pairs.
REQ-039 SHALL cover: back-to-back transactions against the fsm_multiplier model -> 256-block product equals golden n*m.

Source files
------------

// File: rtl/bignum_pkg.sv
// rtl/bignum_pkg.sv - shared bignum sizes and operand streamer state encoding
package bignum_pkg;

  localparam int REGISTER_SIZE = 32;
  localparam int BITS_IN_NUM   = 4096;
  localparam int BLOCKS        = BITS_IN_NUM / REGISTER_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    STREAMING,
    DRAINING,
    WAITING
  } tx_state_t;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv - dual-port block RAM, read-first, registered output (2-cycle read)
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 256
) (
  input  logic                         clka,
  input  logic                         clkb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         rsta,
  input  logic                         rstb,
  input  logic                         regcea,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         douta,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_a_q, ram_b_q;
  logic [RAM_WIDTH-1:0] dout_a_q, dout_b_q;

  // Port B is read-only so the array has a single writing process.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_a_q <= mem[addra];
    end
    if (rsta)        dout_a_q <= '0;
    else if (regcea) dout_a_q <= ram_a_q;
  end

  always_ff @(posedge clkb) begin
    if (enb) ram_b_q <= mem[addrb];
    if (rstb)        dout_b_q <= '0;
    else if (regceb) dout_b_q <= ram_b_q;
  end

  assign douta = dout_a_q;
  assign doutb = dout_b_q;

endmodule

// File: rtl/operand_stream_tx.sv
// rtl/operand_stream_tx.sv - loads two bignum operands and streams them block-pairwise to a multiplier
module operand_stream_tx #(
  parameter  int REGISTER_SIZE = bignum_pkg::REGISTER_SIZE,
  parameter  int BITS_IN_NUM   = bignum_pkg::BITS_IN_NUM,
  localparam int BLOCKS        = BITS_IN_NUM / REGISTER_SIZE,
  localparam int AW            = $clog2(BLOCKS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     load_valid_in,
  input  logic                     load_sel_in,
  input  logic [AW-1:0]            load_addr_in,
  input  logic [REGISTER_SIZE-1:0] load_data_in,
  input  logic                     start_in,
  input  logic                     consumer_ready_in,
  input  logic                     consumer_final_in,
  output logic [REGISTER_SIZE-1:0] n_out,
  output logic [REGISTER_SIZE-1:0] m_out,
  output logic                     valid_out,
  output logic                     busy_out,
  output logic                     done_out
);
  import bignum_pkg::*;

  localparam int RAW = $clog2(2 * BLOCKS);

  tx_state_t          state_q, state_d;
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic [1:0]         vld_q, vld_d;
  logic               done_q, done_d;
  logic               wr_en;
  logic [RAW-1:0]     addr_a, addr_b;
  logic [REGISTER_SIZE-1:0] dout_a, dout_b;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    // vld tracks the two-cycle RAM read pipeline behind each issued address
    vld_d     = {vld_q[0], state_q == STREAMING};
    unique case (state_q)
      IDLE:      if (start_in) state_d = consumer_ready_in ? STREAMING : ARMED;
      ARMED:     if (consumer_ready_in) state_d = STREAMING;
      STREAMING: begin
        if (rd_addr_q == AW'(BLOCKS - 1)) begin
          rd_addr_d = '0;
          state_d   = DRAINING;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      DRAINING:  if (vld_q == 2'b10) state_d = WAITING;
      WAITING:   if (consumer_final_in) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      vld_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
    end
  end

  assign wr_en  = load_valid_in && (state_q == IDLE);
  assign addr_a = wr_en ? RAW'(load_addr_in) + (load_sel_in ? RAW'(BLOCKS) : '0)
                        : RAW'(rd_addr_q);
  assign addr_b = RAW'(rd_addr_q) + RAW'(BLOCKS);

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH(REGISTER_SIZE),
    .RAM_DEPTH(2 * BLOCKS)
  ) u_ram (
    .clka   (clk_in),
    .clkb   (clk_in),
    .addra  (addr_a),
    .addrb  (addr_b),
    .dina   (load_data_in),
    .wea    (wr_en),
    .ena    (1'b1),
    .enb    (1'b1),
    .rsta   (rst_in),
    .rstb   (rst_in),
    .regcea (1'b1),
    .regceb (1'b1),
    .douta  (dout_a),
    .doutb  (dout_b)
  );

  assign valid_out = vld_q[1];
  assign n_out     = vld_q[1] ? dout_a : '0;
  assign m_out     = vld_q[1] ? dout_b : '0;
  assign busy_out  = (state_q != IDLE);
  assign done_out  = done_q;

endmodule

// File: tb/tb_operand_stream_tx.sv
// tb/tb_operand_stream_tx.sv - directed self-checking bench for operand_stream_tx
module tb_operand_stream_tx;
  localparam int NB = 128;

  logic        clk = 1'b0;
  logic        rst_in, load_valid_in, load_sel_in, start_in;
  logic        consumer_ready_in, consumer_final_in;
  logic [6:0]  load_addr_in;
  logic [31:0] load_data_in, n_out, m_out;
  logic        valid_out, busy_out, done_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_n [NB];
  logic [31:0] exp_m [NB];
  logic [31:0] cap_n [NB];
  logic [31:0] cap_m [NB];
  logic [31:0] prod [2*NB];
  logic [4095:0] gn, gm;
  logic [8191:0] gp;
  int lat, cnt;
  bit nz;

  operand_stream_tx dut (
    .clk_in(clk), .rst_in(rst_in), .load_valid_in(load_valid_in), .load_sel_in(load_sel_in),
    .load_addr_in(load_addr_in), .load_data_in(load_data_in), .start_in(start_in),
    .consumer_ready_in(consumer_ready_in), .consumer_final_in(consumer_final_in),
    .n_out(n_out), .m_out(m_out), .valid_out(valid_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_block(input bit sel, input int addr, input logic [31:0] d);
    load_valid_in = 1'b1; load_sel_in = sel; load_addr_in = addr[6:0]; load_data_in = d;
    step();
    load_valid_in = 1'b0;
    if (sel) exp_m[addr] = d; else exp_n[addr] = d;
  endtask

  // Drives start in cycle T; returns in cycle T+1.
  task automatic start_txn(input logic ready);
    start_in = 1'b1; consumer_ready_in = ready;
    step();
    start_in = 1'b0;
  endtask

  task automatic finish_txn();
    consumer_final_in = 1'b1;
    step();
    consumer_final_in = 1'b0;
  endtask

  // Records one stream; cycle 1 is the cycle after start was sampled.
  task automatic capture(input int budget, input int final_at, input int load_at, input int rst_at,
                         output int l, output int c_out, output bit nonzero);
    bit ended;
    ended = 0; l = -1; c_out = 0; nonzero = 0;
    for (int k = 0; k < NB; k++) begin cap_n[k] = 'x; cap_m[k] = 'x; end
    for (int c = 1; c <= budget && !ended; c++) begin
      consumer_final_in = (c == final_at);
      rst_in            = (c == rst_at);
      load_valid_in     = (c == load_at);
      load_sel_in = 1'b0; load_addr_in = 7'd5; load_data_in = 32'hDEAD_BEEF;
      if (valid_out) begin
        if (l < 0) l = c;
        if (c_out < NB) begin cap_n[c_out] = n_out; cap_m[c_out] = m_out; end
        c_out++;
      end else begin
        if (n_out != 0 || m_out != 0) nonzero = 1;
        if (c_out > 0) ended = 1;
      end
      if (!ended) step();
    end
    consumer_final_in = 1'b0; rst_in = 1'b0; load_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b1; consumer_ready_in = 1'b1;
    repeat (3) step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_out); end
    checks++; if (n_out !== 32'd0 || m_out !== 32'd0) begin errors++; $display("FAIL reset_data: got n=%h m=%h expected 0", n_out, m_out); end
    rst_in = 1'b0; start_in = 1'b0;
    step();
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy_out); end
  endtask

  task automatic test_stream_basic();
    for (int k = 0; k < NB; k++) load_block(0, k, 32'(k + 1));
    for (int k = 0; k < NB; k++) load_block(1, k, 32'h8000_0000 + 32'(k));
    start_txn(1'b1);
    consumer_ready_in = 1'b0;
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy_out); end
    capture(200, -1, -1, -1, lat, cnt, nz);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    checks++; if (cnt !== NB) begin errors++; $display("FAIL basic_count: got %0d expected %0d", cnt, NB); end
    checks++; if (nz !== 1'b0) begin errors++; $display("FAIL basic_zero_when_invalid: got %b expected 0", nz); end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (cap_n[k] !== 32'(k + 1) || cap_m[k] !== 32'h8000_0000 + 32'(k)) begin
        errors++; $display("FAIL basic_pair%0d: got n=%h m=%h expected n=%h m=%h", k, cap_n[k], cap_m[k], 32'(k + 1), 32'h8000_0000 + 32'(k));
      end
    end
    finish_txn();
  endtask

  task automatic test_armed();
    start_txn(1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (valid_out !== 1'b0 || busy_out !== 1'b1) begin errors++; $display("FAIL armed_hold%0d: got valid=%b busy=%b expected valid=0 busy=1", i, valid_out, busy_out); end
      step();
    end
    consumer_ready_in = 1'b1;
    step();
    capture(200, -1, -1, -1, lat, cnt, nz);
    checks++; if (lat !== 3) begin errors++; $display("FAIL armed_latency: got %0d expected 3", lat); end
    checks++; if (cnt !== NB) begin errors++; $display("FAIL armed_count: got %0d expected %0d", cnt, NB); end
    checks++; if (cap_n[NB-1] !== exp_n[NB-1] || cap_m[0] !== exp_m[0]) begin errors++; $display("FAIL armed_data: got n127=%h m0=%h expected %h %h", cap_n[NB-1], cap_m[0], exp_n[NB-1], exp_m[0]); end
    finish_txn();
  endtask

  task automatic test_final();
    start_txn(1'b1);
    capture(200, 50, -1, -1, lat, cnt, nz);
    checks++; if (cnt !== NB) begin errors++; $display("FAIL final_count: got %0d expected %0d", cnt, NB); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (busy_out !== 1'b1 || done_out !== 1'b0) begin errors++; $display("FAIL final_waiting%0d: got busy=%b done=%b expected busy=1 done=0", i, busy_out, done_out); end
      step();
    end
    finish_txn();
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL final_done: got %b expected 1", done_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL final_busy: got %b expected 0", busy_out); end
    step();
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL final_done_pulse: got %b expected 0", done_out); end
  endtask

  task automatic test_load_during_stream();
    start_txn(1'b1);
    capture(200, -1, 20, -1, lat, cnt, nz);
    finish_txn();
    start_txn(1'b1);
    capture(200, -1, -1, -1, lat, cnt, nz);
    checks++; if (cnt !== NB) begin errors++; $display("FAIL ignload_count: got %0d expected %0d", cnt, NB); end
    checks++; if (cap_n[5] !== 32'd6) begin errors++; $display("FAIL ignload_n5: got %h expected 00000006", cap_n[5]); end
    finish_txn();
  endtask

  task automatic test_reset_mid_stream();
    start_txn(1'b1);
    capture(200, -1, -1, 43, lat, cnt, nz);
    checks++; if (cnt !== 41) begin errors++; $display("FAIL rstmid_count: got %0d expected 41", cnt); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_out); end
    nz = 0;
    for (int i = 0; i < 10; i++) begin if (valid_out !== 1'b0) nz = 1; step(); end
    checks++; if (nz !== 1'b0) begin errors++; $display("FAIL rstmid_no_pairs: got valid after reset expected none"); end
    start_txn(1'b1);
    capture(200, -1, -1, -1, lat, cnt, nz);
    checks++; if (lat !== 3 || cnt !== NB) begin errors++; $display("FAIL rstmid_restart: got lat=%0d cnt=%0d expected 3 %0d", lat, cnt, NB); end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (cap_n[k] !== exp_n[k] || cap_m[k] !== exp_m[k]) begin
        errors++; $display("FAIL rstmid_pair%0d: got n=%h m=%h expected n=%h m=%h", k, cap_n[k], cap_m[k], exp_n[k], exp_m[k]);
      end
    end
    finish_txn();
  endtask

  task automatic test_load_and_start();
    load_valid_in = 1'b1; load_sel_in = 1'b1; load_addr_in = 7'd127; load_data_in = 32'h0BAD_F00D;
    start_in = 1'b1; consumer_ready_in = 1'b1;
    step();
    load_valid_in = 1'b0; start_in = 1'b0;
    exp_m[127] = 32'h0BAD_F00D;
    capture(200, -1, -1, -1, lat, cnt, nz);
    checks++; if (lat !== 3 || cnt !== NB) begin errors++; $display("FAIL ldstart_timing: got lat=%0d cnt=%0d expected 3 %0d", lat, cnt, NB); end
    checks++; if (cap_m[127] !== 32'h0BAD_F00D) begin errors++; $display("FAIL ldstart_m127: got %h expected 0badf00d", cap_m[127]); end
    finish_txn();
  endtask

  // Consumer model: schoolbook 32-bit limb product of the captured stream vs. wide golden n*m.
  task automatic test_back_to_back();
    logic [63:0] t;
    logic [31:0] carry;
    for (int k = 0; k < NB; k++) load_block(0, k, $urandom);
    for (int k = 0; k < NB; k++) load_block(1, k, $urandom);
    for (int k = 0; k < NB; k++) begin gn[32*k +: 32] = exp_n[k]; gm[32*k +: 32] = exp_m[k]; end
    gp = {4096'b0, gn} * {4096'b0, gm};
    for (int tr = 0; tr < 2; tr++) begin
      start_txn(1'b1);
      capture(200, -1, -1, -1, lat, cnt, nz);
      checks++; if (cnt !== NB) begin errors++; $display("FAIL b2b%0d_count: got %0d expected %0d", tr, cnt, NB); end
      for (int i = 0; i < 2*NB; i++) prod[i] = 32'd0;
      for (int i = 0; i < NB; i++) begin
        carry = 32'd0;
        for (int j = 0; j < NB; j++) begin
          t = 64'(cap_n[i]) * 64'(cap_m[j]) + 64'(prod[i+j]) + 64'(carry);
          prod[i+j] = t[31:0];
          carry = t[63:32];
        end
        prod[i+NB] = carry;
      end
      for (int k = 0; k < 2*NB; k++) begin
        checks++;
        if (prod[k] !== gp[32*k +: 32]) begin errors++; $display("FAIL b2b%0d_prod%0d: got %h expected %h", tr, k, prod[k], gp[32*k +: 32]); end
      end
      finish_txn();
      checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL b2b%0d_done: got %b expected 1", tr, done_out); end
    end
  endtask

  initial begin
    rst_in = 1'b1; load_valid_in = 1'b0; load_sel_in = 1'b0; load_addr_in = '0; load_data_in = '0;
    start_in = 1'b0; consumer_ready_in = 1'b0; consumer_final_in = 1'b0;
    step();
    test_reset();
    test_stream_basic();
    test_armed();
    test_final();
    test_load_during_stream();
    test_reset_mid_stream();
    test_load_and_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
